// File: rtl/multicycle_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: opcodes, FSM states, mux codes, control word.
// MULTICYCLE_ADDI_EN adds ADDI decoding through EXEC_I/I_WB.
package multicycle_pkg;

    localparam int unsigned OPC_W   = 6;
    localparam int unsigned ST_BITS = 4;

    localparam logic [OPC_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPC_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPC_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPC_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPC_W-1:0] OP_J     = 6'b000010;
    localparam logic [OPC_W-1:0] OP_ADDI  = 6'b001000;

    typedef enum logic [ST_BITS-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_EXEC_I   = 4'd10,
        S_I_WB     = 4'd11
    } state_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       ir_we;
        logic       pc_we;
        logic       reg_we;
        logic       dm_we;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       illegal;
    } ctrl_t;

    // Opcodes the FSM knows how to sequence; anything else raises illegal in DECODE.
    function automatic logic op_legal(input logic [OPC_W-1:0] op);
        logic ok;
        ok = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
             (op == OP_BEQ)   || (op == OP_J);
`ifdef MULTICYCLE_ADDI_EN
        ok = ok || (op == OP_ADDI);
`endif
        return ok;
    endfunction

endpackage

// File: rtl/multicycle_out_dec.sv
// Moore control-word decoder: maps the current state (plus ready/zero qualifiers) to datapath controls.
// MULTICYCLE_ADDI_EN enables the EXEC_I/I_WB control words.
module multicycle_out_dec
    import multicycle_pkg::*;
(
    input  state_t state_i,
    input  logic   rdy_i,
    input  logic   zero_i,
    input  logic   legal_i,
    output ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_req   = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.ir_we     = rdy_i;
                ctrl_o.pc_we     = rdy_i;
            end
            S_DECODE: begin
                ctrl_o.alu_src_b = SRCB_IMM_SH;
                ctrl_o.illegal   = ~legal_i;
            end
            S_MEM_ADDR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
            end
            S_MEM_RD: begin
                ctrl_o.mem_req = 1'b1;
                ctrl_o.iord    = 1'b1;
            end
            S_MEM_WB: begin
                ctrl_o.reg_we     = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                ctrl_o.mem_req = 1'b1;
                ctrl_o.iord    = 1'b1;
                ctrl_o.dm_we   = rdy_i;
            end
            S_EXEC_R: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_RT;
                ctrl_o.alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                ctrl_o.reg_we  = 1'b1;
                ctrl_o.reg_dst = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_RT;
                ctrl_o.alu_op    = ALU_SUB;
                ctrl_o.pc_src    = PCS_ALUOUT;
                ctrl_o.pc_we     = zero_i;
            end
            S_JUMP: begin
                ctrl_o.pc_src = PCS_JUMP;
                ctrl_o.pc_we  = 1'b1;
            end
`ifdef MULTICYCLE_ADDI_EN
            S_EXEC_I: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALU_ADD;
            end
            S_I_WB: begin
                ctrl_o.reg_we = 1'b1;
            end
`endif
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: state register and next-state logic; controls come from multicycle_out_dec.
// MULTICYCLE_ADDI_EN adds the ADDI path DECODE -> EXEC_I -> I_WB -> FETCH.
module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter int unsigned OP_W    = 6,
    parameter int unsigned FUNCT_W = 6,
    parameter int unsigned ST_W    = 4
) (
    input  logic               clk_i,
    input  logic               rst_n,
    input  logic [OP_W-1:0]    OP,
    input  logic [FUNCT_W-1:0] funct,
    input  logic               zero_i,
    input  logic               mem_ready_i,
    output logic               mem_req_o,
    output logic               IorD,
    output logic               IR_WE,
    output logic               PC_WE,
    output logic               Reg_WE,
    output logic               DM_WE,
    output logic               MEM_to_REG,
    output logic               REG_Dst,
    output logic               ALU_src_A,
    output logic [1:0]         ALU_src_B,
    output logic [1:0]         ALU_OP,
    output logic [1:0]         PC_src,
    output logic               illegal_o,
    output logic [ST_W-1:0]    state_o
);

    state_t           state_q;
    state_t           state_d;
    logic [OPC_W-1:0] op_c;
    logic             rdy_c;
    ctrl_t            ctrl_c;
    logic             unused_funct;

    assign op_c         = OPC_W'(OP);
    assign unused_funct = ^funct;
    // Forcing ready low under reset keeps every write enable quiet while rst_n is asserted.
    assign rdy_c        = mem_ready_i & rst_n;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = mem_ready_i ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op_c)
                    OP_RTYPE:     state_d = S_EXEC_R;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
`ifdef MULTICYCLE_ADDI_EN
                    OP_ADDI:      state_d = S_EXEC_I;
`endif
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR: state_d = (op_c == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   state_d = mem_ready_i ? S_MEM_WB : S_MEM_RD;
            S_MEM_WB:   state_d = S_FETCH;
            S_MEM_WR:   state_d = mem_ready_i ? S_FETCH : S_MEM_WR;
            S_EXEC_R:   state_d = S_R_WB;
            S_R_WB:     state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
`ifdef MULTICYCLE_ADDI_EN
            S_EXEC_I:   state_d = S_I_WB;
            S_I_WB:     state_d = S_FETCH;
`endif
            default:    state_d = S_FETCH;
        endcase
    end

    multicycle_out_dec u_out_dec (
        .state_i (state_q),
        .rdy_i   (rdy_c),
        .zero_i  (zero_i),
        .legal_i (op_legal(op_c)),
        .ctrl_o  (ctrl_c)
    );

    assign mem_req_o  = ctrl_c.mem_req;
    assign IorD       = ctrl_c.iord;
    assign IR_WE      = ctrl_c.ir_we;
    assign PC_WE      = ctrl_c.pc_we;
    assign Reg_WE     = ctrl_c.reg_we;
    assign DM_WE      = ctrl_c.dm_we;
    assign MEM_to_REG = ctrl_c.mem_to_reg;
    assign REG_Dst    = ctrl_c.reg_dst;
    assign ALU_src_A  = ctrl_c.alu_src_a;
    assign ALU_src_B  = ctrl_c.alu_src_b;
    assign ALU_OP     = ctrl_c.alu_op;
    assign PC_src     = ctrl_c.pc_src;
    assign illegal_o  = ctrl_c.illegal;
    assign state_o    = ST_W'(state_q);

endmodule
